// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives stage register enables/flushes,
// launches multi-cycle MDU ops held in EX, and keeps stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             ex_mdu_op,
  input  logic             mdu_done,
  input  logic             mem_busy,
  input  logic             trap,
  output logic             pc_en,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             mdu_start,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t      state_q, state_d;
  logic [16:0] tcnt_q, tcnt_d;
  logic        timeout_d;
  logic        flush_ev;
  logic        load_use;

  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en        = 1'b1;
    en_if_id     = 1'b1;
    en_id_ex     = 1'b1;
    en_ex_mem    = 1'b1;
    en_mem_wb    = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    mdu_start    = 1'b0;
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    timeout_d    = mdu_timeout;
    flush_ev     = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      en_if_id     = 1'b0;
      en_id_ex     = 1'b0;
      en_ex_mem    = 1'b0;
      en_mem_wb    = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (mem_busy) begin
      pc_en     = 1'b0;
      en_if_id  = 1'b0;
      en_id_ex  = 1'b0;
      en_ex_mem = 1'b0;
      en_mem_wb = 1'b0;
    end else if (trap) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      state_d      = RUN;
      flush_ev     = 1'b1;
    end else if (state_q == MDU_WAIT) begin
      if (mdu_done) begin
        state_d = RUN;
      end else begin
        pc_en        = 1'b0;
        en_if_id     = 1'b0;
        en_id_ex     = 1'b0;
        flush_ex_mem = 1'b1;
        // Counter saturates at the limit; the flag sets on the edge it gets there.
        if (tcnt_q < 17'(MDU_TIMEOUT)) tcnt_d = tcnt_q + 17'd1;
        if (tcnt_q + 17'd1 >= 17'(MDU_TIMEOUT)) timeout_d = 1'b1;
      end
    end else if (ex_mdu_op) begin
      mdu_start    = 1'b1;
      pc_en        = 1'b0;
      en_if_id     = 1'b0;
      en_id_ex     = 1'b0;
      flush_ex_mem = 1'b1;
      state_d      = MDU_WAIT;
      tcnt_d       = 17'd1;
    end else if (ex_redirect) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      flush_ev    = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      en_if_id    = 1'b0;
      flush_id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      tcnt_q      <= '0;
      mdu_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      mdu_timeout <= timeout_d;
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares each cycle's outputs.
module tb_pipe_hazard_ctrl;
  localparam int unsigned CNT_W = 32;

  // {pc_en,en_if_id,en_id_ex,en_ex_mem,en_mem_wb,fl_if_id,fl_id_ex,fl_ex_mem,mdu_start,mdu_timeout}
  localparam logic [9:0] C_RST = 10'b00000_111_0_0;
  localparam logic [9:0] C_NRM = 10'b11111_000_0_0;
  localparam logic [9:0] C_LU  = 10'b00111_010_0_0;
  localparam logic [9:0] C_MST = 10'b00011_001_0_0;
  localparam logic [9:0] C_MGO = 10'b00011_001_1_0;
  localparam logic [9:0] C_FRZ = 10'b00000_000_0_0;
  localparam logic [9:0] C_TRP = 10'b11111_111_0_0;
  localparam logic [9:0] C_RDR = 10'b11111_110_0_0;
  localparam logic [9:0] TO    = 10'b00000_000_0_1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic ex_is_load = 1'b0, ex_redirect = 1'b0, ex_mdu_op = 1'b0;
  logic mdu_done = 1'b0, mem_busy = 1'b0, trap = 1'b0;
  logic pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, mdu_start, mdu_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MDU_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .ex_mdu_op(ex_mdu_op), .mdu_done(mdu_done), .mem_busy(mem_busy), .trap(trap),
    .pc_en(pc_en), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
    .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .mdu_start(mdu_start), .mdu_timeout(mdu_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [9:0]  ctl;
    int unsigned st;
    int unsigned fl;
  } exp_t;

  exp_t sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [9:0] act;
      e   = sb.pop_front();
      act = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
             flush_if_id, flush_id_ex, flush_ex_mem, mdu_start, mdu_timeout};
      n_tests++;
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b expected %b", e.nm, act, e.ctl);
      end
      n_tests++;
      if (stall_cnt !== CNT_W'(e.st)) begin
        n_fail++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", e.nm, stall_cnt, e.st);
      end
      n_tests++;
      if (flush_cnt !== CNT_W'(e.fl)) begin
        n_fail++;
        $display("FAIL %s flush_cnt: got %0d expected %0d", e.nm, flush_cnt, e.fl);
      end
    end
  end

  task automatic v(input string nm, input logic r, bsy, tr, mdu, dn, rdr, ld,
                   input logic [4:0] rd, s1, input logic u1,
                   input logic [4:0] s2, input logic u2,
                   input logic [9:0] ctl, input int unsigned st, fl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mem_busy = bsy; trap = tr; ex_mdu_op = mdu; mdu_done = dn;
    ex_redirect = rdr; ex_is_load = ld; ex_rd = rd;
    id_rs1 = s1; id_rs1_used = u1; id_rs2 = s2; id_rs2_used = u2;
    e.nm = nm; e.ctl = ctl; e.st = st; e.fl = fl;
    sb.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    //         name          r bsy tr mdu dn rdr ld rd s1 u1 s2 u2  ctl        st  fl
    v("rst_a",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,      0,  0);
    v("rst_b",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,      0,  0);
    v("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM,      0,  0);
    v("lu_rs1",      0, 0, 0, 0, 0, 0, 1, 5, 5, 1, 7, 1, C_LU,       0,  0);
    v("lu_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM,      1,  0);
    v("lu_x0",       0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, C_NRM,      1,  0);
    v("lu_rs2",      0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 7, 1, C_LU,       1,  0);
    v("lu_unused",   0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 3, 1, C_NRM,      2,  0);
    v("redir_lu",    0, 0, 0, 0, 0, 1, 1, 5, 5, 1, 0, 0, C_RDR,      2,  0);
    v("mdu_start",   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_MGO,      2,  1);
    v("mdu_w1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MST,      3,  1);
    v("mdu_w2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MST,      4,  1);
    v("mdu_done",    0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_NRM,      5,  1);
    v("mdu_rdr_ign", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, C_MGO,      5,  1);
    v("busy_1",      0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_FRZ,      6,  1);
    v("busy_2",      0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_FRZ,      7,  1);
    v("busy_3",      0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_FRZ,      8,  1);
    v("held_w1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MST,      9,  1);
    v("held_w2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MST,     10,  1);
    v("held_done",   0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_NRM,     11,  1);
    v("run_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM,     11,  1);
    v("to_start",    0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_MGO,     11,  1);
    v("to_w1",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MST,     12,  1);
    v("to_w2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MST,     13,  1);
    v("to_w3",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MST,     14,  1);
    v("to_w4",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MST | TO, 15,  1);
    v("to_w5",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MST | TO, 16,  1);
    v("trap_wait",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_TRP | TO, 17,  1);
    v("post_trap",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM | TO, 17,  2);
    v("trap_lu",     0, 0, 1, 0, 0, 0, 1, 5, 5, 1, 0, 0, C_TRP | TO, 17,  2);
    v("busy_trap",   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_FRZ | TO, 17,  3);
    v("idle2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM | TO, 18,  3);
    v("mdu_pre_rst", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_MGO | TO, 18,  3);
    v("rst_mid",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST | TO, 19,  3);
    v("post_rst",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NRM,      0,  0);
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
